// File: rtl/md_pkg.sv
// Shared encodings and default width for the multiply/divide unit.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mdState_t;

endpackage

// File: rtl/md_div_core.sv
// Magnitude restoring divider: one quotient bit per step, WIDTH steps after load.
// Latency WIDTH steps; no backpressure, the owner sequences load/step.
module md_div_core
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] divisorReg;
  logic [WIDTH:0]   shifted;
  logic             borrow;

  // The partial remainder can reach 2*divisor-1, so the trial uses one extra bit.
  assign shifted = {rem, quo[WIDTH-1]};
  assign borrow  = shifted < {1'b0, divisorReg};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      quo        <= '0;
      rem        <= '0;
      divisorReg <= '0;
    end else if (load) begin
      quo        <= dividend;
      rem        <= '0;
      divisorReg <= divisor;
    end else if (step) begin
      if (borrow) begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end else begin
        rem <= WIDTH'(shifted - {1'b0, divisorReg});
        quo <= {quo[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Signed MULT (radix-2 Booth) / DIV (restoring) unit; done WIDTH+1 cycles after start, start ignored while busy.
// Optional MD_UNSIGNED_EN adds the uns port for MULTU/DIVU.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MD_UNSIGNED_EN
  input  logic             uns,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  logic unsIn;
`ifdef MD_UNSIGNED_EN
  assign unsIn = uns;
`else
  assign unsIn = 1'b0;
`endif

  mdState_t         state;
  logic [CW-1:0]    count;
  logic             opReg, unsReg, zeroFlag, negQ, negR;
  logic [WIDTH-1:0] aReg, bReg;
  logic [WIDTH:0]   pHi;
  logic [WIDTH-1:0] pLo;
  logic             q1;

  logic [WIDTH:0]   aExt, boothSum;
  logic [WIDTH-1:0] aMag, bMag, divQuo, divRem, prodHi;
  logic             accept;

  assign accept = (state == IDLE) && start && !done;
  assign aMag   = (!unsIn && a[WIDTH-1]) ? -a : a;
  assign bMag   = (!unsIn && b[WIDTH-1]) ? -b : b;

  // Upper half is one bit wider so that subtracting the most negative multiplicand cannot overflow.
  assign aExt = {(unsReg ? 1'b0 : aReg[WIDTH-1]), aReg};

  always_comb begin
    boothSum = pHi;
    case ({pLo[0], q1})
      2'b01:   boothSum = pHi + aExt;
      2'b10:   boothSum = pHi - aExt;
      default: boothSum = pHi;
    endcase
  end

  // Booth treats the multiplier as signed; an unsigned multiplier with its top bit set needs a<<WIDTH more.
  assign prodHi = pHi[WIDTH-1:0] + ((unsReg && bReg[WIDTH-1]) ? aReg : '0);

  md_div_core #(.WIDTH(WIDTH)) uDivCore (
    .clock    (clock),
    .reset    (reset),
    .load     (accept && (op == MD_OP_DIV)),
    .step     ((state == RUN) && (opReg == MD_OP_DIV)),
    .dividend (aMag),
    .divisor  (bMag),
    .quo      (divQuo),
    .rem      (divRem)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      opReg    <= MD_OP_MULT;
      unsReg   <= 1'b0;
      zeroFlag <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      aReg     <= '0;
      bReg     <= '0;
      pHi      <= '0;
      pLo      <= '0;
      q1       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            opReg    <= op;
            unsReg   <= unsIn;
            aReg     <= a;
            bReg     <= b;
            count    <= CW'(WIDTH - 1);
            negQ     <= !unsIn && (a[WIDTH-1] ^ b[WIDTH-1]);
            negR     <= !unsIn && a[WIDTH-1];
            pHi      <= '0;
            pLo      <= b;
            q1       <= 1'b0;
            zeroFlag <= (op == MD_OP_DIV) && (b == '0);
            busy     <= 1'b1;
            state    <= ((op == MD_OP_DIV) && (b == '0)) ? FIN : RUN;
          end
        end
        RUN: begin
          if (opReg == MD_OP_MULT) begin
            {pHi, pLo, q1} <= {boothSum[WIDTH], boothSum, pLo};
          end
          if (count == '0) begin
            state <= FIN;
          end else begin
            count <= count - 1'b1;
          end
        end
        FIN: begin
          done     <= 1'b1;
          div_zero <= zeroFlag;
          busy     <= 1'b0;
          state    <= IDLE;
          if (!zeroFlag) begin
            if (opReg == MD_OP_MULT) begin
              hi <= prodHi;
              lo <= pLo;
            end else begin
              hi <= negR ? -divRem : divRem;
              lo <= negQ ? -divQuo : divQuo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Vector table plus scoreboard bench for mult_div_unit (signed build).
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          op    = 1'b0;
  logic          uns   = 1'b0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic [W-1:0]  hi, lo;
  logic          busy, done, div_zero;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
`ifdef MD_UNSIGNED_EN
    .uns      (uns),
`endif
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
    logic         expZero;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    int           lat;
  } exp_t;

  exp_t   sb[$];
  vec_t   vecs[14];
  int     checks   = 0;
  int     failures = 0;
  logic [W-1:0] lastHi = '0;
  logic [W-1:0] lastLo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] pHi, input logic [W-1:0] pLo);
    exp_t   e;
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.zero = 1'b0;
    e.lat  = W + 1;
    if (o == 1'b0) begin
      p    = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.hi   = pHi;
      e.lo   = pLo;
      e.zero = 1'b1;
      e.lat  = 1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Drives one request, pushes its expectation, then waits for done and scores it.
  task automatic doOp(input string name, input logic o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input exp_t e);
    int   lat;
    exp_t got;
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    if (!done) begin
      check({name, "_timeout"}, 64'(lat), 64'(e.lat));
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    got = sb.pop_front();
    check({name, "_hi"}, 64'(hi), 64'(got.hi));
    check({name, "_lo"}, 64'(lo), 64'(got.lo));
    check({name, "_divzero"}, 64'(div_zero), 64'(got.zero));
    check({name, "_latency"}, 64'(lat), 64'(got.lat));
    lastHi = got.hi;
    lastLo = got.lo;
    @(negedge clock);
    check({name, "_done_pulse"}, 64'({done, div_zero}), 64'd0);
  endtask

  initial begin
    exp_t e;
    int   nDone;
    logic o;
    logic [W-1:0] x, y;

    vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0};
    vecs[5]  = '{1'b1, 32'd5,         32'd0,         32'h0000_0011, 32'h0000_0022, 1'b1};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};
    vecs[9]  = '{1'b1, 32'd3,         32'd5,         32'd3,         32'd0,         1'b0};
    vecs[10] = '{1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};
    vecs[12] = '{1'b1, 32'h7FFF_FFFF, 32'd1,         32'd0,         32'h7FFF_FFFF, 1'b0};
    vecs[13] = '{1'b1, 32'h8000_0000, 32'd0,         32'd0,         32'h7FFF_FFFF, 1'b1};

    #12;
    check("reset_outputs", {hi, lo}, 64'd0);
    check("reset_flags", 64'({busy, done, div_zero}), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      e.hi   = vecs[i].expHi;
      e.lo   = vecs[i].expLo;
      e.zero = vecs[i].expZero;
      e.lat  = vecs[i].expZero ? 1 : W + 1;
      doOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
    end

    for (int i = 0; i < 8; i++) begin
      o = $urandom_range(0, 1);
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 3 == 1) x = -x;
      doOp($sformatf("rnd%0d", i), o, x, y, model(o, x, y, lastHi, lastLo));
    end

    // Start pulses during RUN, FIN and the done cycle must all be dropped.
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'h0001_2345; b = 32'hFFFF_0F0F;
    e = model(1'b0, a, b, lastHi, lastLo);
    sb.push_back(e);
    nDone = 0;
    for (int m = 1; m <= 45; m++) begin
      @(posedge clock);
      @(negedge clock);
      start = (m == 5 || m == 33 || m == 34);
      op = 1'b0; a = 32'd9; b = 32'd9;
      if (m == 20 || m == 33) check($sformatf("ignore_busy_m%0d", m), 64'(busy), 64'd1);
      if (done) begin
        nDone++;
        check("ignore_done_cycle", 64'(m), 64'(W + 2));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ignore_hi", 64'(hi), 64'(e.hi));
          check("ignore_lo", 64'(lo), 64'(e.lo));
          lastHi = e.hi;
          lastLo = e.lo;
        end
      end
    end
    start = 1'b0;
    check("ignore_done_count", 64'(nDone), 64'd1);
    check("ignore_idle_after", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clock);
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_flags", 64'({busy, done, div_zero}), 64'd0);
    lastHi = '0;
    lastLo = '0;
    @(negedge clock);
    reset = 1'b1;
    e.hi = 32'd0; e.lo = 32'd12; e.zero = 1'b0; e.lat = W + 1;
    doOp("post_reset_mult", 1'b0, 32'd3, 32'd4, e);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
